tx_fifo_wr_sched: RTL and testbench

Write-side scheduler for the transmit FIFO, clocked in the parallel (wclk) domain. It shares the FIFO's single write port between two word requesters, port 0 (CPU register path) and port 1 (DMA path), using round-robin arbitration. In stereo operation it locks the write port to one requester for a full left/right word pair, so channel order in the FIFO is never interleaved. It drives the FIFO `wr_en`/`din` directly and honours the FIFO's registered `full` flag.

---
 rtl/tx_fifo_wr_sched_if.sv | 27 ++
 rtl/tx_fifo_wr_sched.sv | 166 ++++++++++++++++
 tb/tb_tx_fifo_wr_sched.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_fifo_wr_sched_if.sv
// Bus bundle for the transmit FIFO write scheduler: two word requesters
// (port 0 = CPU register path, port 1 = DMA path) and the FIFO write port.
// The scheduler uses the slave modport. The requesters and the FIFO side use
// the master modport.
interface tx_fifo_wr_sched_if #(
  parameter int WIDTH = 32
) ();
  logic             s0_valid;
  logic [WIDTH-1:0] s0_data;
  logic             s0_ready;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [WIDTH-1:0] fifo_din;

  modport master (
    output s0_valid, s0_data, s1_valid, s1_data, fifo_full,
    input  s0_ready, s1_ready, fifo_wr_en, fifo_din
  );

  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data, fifo_full,
    output s0_ready, s1_ready, fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/tx_fifo_wr_sched.sv
// Write-side scheduler for the transmit FIFO (wclk domain).
// Round-robin sharing of the single FIFO write port between port 0 and port 1.
// In stereo mode a grant covers a left/right word pair, so the channels of a
// pair are never interleaved with the other port's words.
// Optional feature macro: TXSCHED_TIMEOUT_EN. It enables the abort of a pair
// whose right word does not arrive within TIMEOUT stall cycles.
module tx_fifo_wr_sched #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              wclk,
  input  logic              rst_,
  input  logic              enable,
  input  logic              stereo,
  tx_fifo_wr_sched_if.slave bus,
  output logic [1:0]        grant,
  output logic [15:0]       pair_cnt,
  output logic              pair_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("tx_fifo_wr_sched: TIMEOUT must be within 1..255");
  end

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;      // 1 = port 1 was served last
  logic [15:0]      pair_cnt_q, pair_cnt_d;
  logic             active_s;
  logic             gvalid_s;
  logic             accept_s;
  logic [WIDTH-1:0] din_s;

`ifdef TXSCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);
  logic [TW-1:0] tmo_q, tmo_d, tmo_inc_s;
  logic          pair_err_q, pair_err_d;
  assign tmo_inc_s = tmo_q + TW'(1);
  assign pair_err  = pair_err_q;
`else
  assign pair_err  = 1'b0;
`endif

  // The write port is open only while a grant is held. A registered full
  // flag closes the port, so the FIFO never sees a write it would drop.
  assign active_s       = (state_q == ST_LEFT) || (state_q == ST_RIGHT);
  assign gvalid_s       = (grant_q[0] & bus.s0_valid) | (grant_q[1] & bus.s1_valid);
  assign accept_s       = active_s && gvalid_s && !bus.fifo_full;
  assign bus.s0_ready   = active_s && grant_q[0] && !bus.fifo_full;
  assign bus.s1_ready   = active_s && grant_q[1] && !bus.fifo_full;
  assign din_s          = grant_q[1] ? bus.s1_data : bus.s0_data;
  assign bus.fifo_din   = din_s;
  assign bus.fifo_wr_en = accept_s;
  assign grant          = grant_q;
  assign pair_cnt       = pair_cnt_q;

  // Next-state, grant, round-robin pointer and completion counter.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    pair_cnt_d = pair_cnt_q;
`ifdef TXSCHED_TIMEOUT_EN
    tmo_d      = tmo_q;
    pair_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable && (bus.s0_valid || bus.s1_valid)) begin
          state_d = ST_LEFT;
          // Port 0 wins when it is the only requester or port 1 went last.
          if (bus.s0_valid && (!bus.s1_valid || last_q)) begin
            grant_d = 2'b01;
          end else begin
            grant_d = 2'b10;
          end
        end else begin
          grant_d = 2'b00;
        end
      end
      ST_LEFT: begin
        if (accept_s) begin
          if (stereo) begin
            state_d = ST_RIGHT;
`ifdef TXSCHED_TIMEOUT_EN
            tmo_d   = {TW{1'b0}};
`endif
          end else begin
            state_d    = ST_IDLE;
            grant_d    = 2'b00;
            last_d     = grant_q[1];
            pair_cnt_d = pair_cnt_q + 16'd1;
          end
        end else if (!enable) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end else begin
          state_d = ST_LEFT;
        end
      end
      ST_RIGHT: begin
        // The enable input is ignored here: a started pair always finishes.
        if (accept_s) begin
          state_d    = ST_IDLE;
          grant_d    = 2'b00;
          last_d     = grant_q[1];
          pair_cnt_d = pair_cnt_q + 16'd1;
`ifdef TXSCHED_TIMEOUT_EN
        end else if (!gvalid_s && !bus.fifo_full) begin
          if (tmo_inc_s == TMO_LIM) begin
            state_d    = ST_IDLE;
            grant_d    = 2'b00;
            last_d     = grant_q[1];
            pair_err_d = 1'b1;
            tmo_d      = {TW{1'b0}};
          end else begin
            tmo_d = tmo_inc_s;
          end
`endif
        end else begin
          state_d = ST_RIGHT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Scheduler state register.
  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= ST_IDLE;
      grant_q    <= 2'b00;
      last_q     <= 1'b1;
      pair_cnt_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

`ifdef TXSCHED_TIMEOUT_EN
  // Right-word stall counter and abort pulse.
  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      tmo_q      <= {TW{1'b0}};
      pair_err_q <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      pair_err_q <= pair_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_tx_fifo_wr_sched.sv
// Self-checking bench for tx_fifo_wr_sched. It runs directed scenarios and a
// randomized run that is compared against a grant-level reference model.
module tb_tx_fifo_wr_sched;
  localparam int WIDTH = 32;
  localparam int TMO   = 4;

  logic        wclk = 1'b0;
  logic        rst_;
  logic        enable;
  logic        stereo;
  logic [1:0]  grant;
  logic [15:0] pair_cnt;
  logic        pair_err;
  int          n_cmp = 0;
  int          n_bad = 0;

  tx_fifo_wr_sched_if #(.WIDTH(WIDTH)) bus ();

  tx_fifo_wr_sched #(.WIDTH(WIDTH), .TIMEOUT(TMO)) dut (
    .wclk     (wclk),
    .rst_     (rst_),
    .enable   (enable),
    .stereo   (stereo),
    .bus      (bus.slave),
    .grant    (grant),
    .pair_cnt (pair_cnt),
    .pair_err (pair_err)
  );

  always #5 wclk = ~wclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic en, input logic st, input logic v0, input logic v1,
                       input logic full, input logic [31:0] d0, input logic [31:0] d1);
    enable        = en;
    stereo        = st;
    bus.s0_valid  = v0;
    bus.s1_valid  = v1;
    bus.fifo_full = full;
    bus.s0_data   = d0;
    bus.s1_data   = d1;
  endtask

  task automatic apply_reset;
    @(negedge wclk);
    rst_ = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge wclk);
    @(negedge wclk);
    rst_ = 1'b1;
  endtask

  task automatic test_reset;
    rst_ = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h11111111, 32'h22222222);
    #1;
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant got %b want 00", grant); end
    n_cmp++; if (pair_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_cnt got %h want 0000", pair_cnt); end
    n_cmp++; if (pair_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", pair_err); end
    n_cmp++; if ({bus.s0_ready, bus.s1_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", {bus.s0_ready, bus.s1_ready}); end
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr got %b want 0", bus.fifo_wr_en); end
    n_cmp++; if (bus.fifo_din !== 32'h11111111) begin n_bad++; $display("FAIL reset_din got %h want 11111111", bus.fifo_din); end
    @(negedge wclk);
    @(negedge wclk);
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_hold_grant got %b want 00", grant); end
    rst_ = 1'b1;
  endtask

  task automatic test_pair_basic;
    apply_reset();
    @(negedge wclk); drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA0000001, 32'h0); #1;
    n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL basic_c0_wr got %b want 0", bus.fifo_wr_en); end
    @(negedge wclk); #1;
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL basic_c1_grant got %b want 01", grant); end
    n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 32'hA0000001) begin n_bad++; $display("FAIL basic_c1_write got wr=%b din=%h want wr=1 din=a0000001", bus.fifo_wr_en, bus.fifo_din); end
    @(negedge wclk); drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA0000002, 32'h0); #1;
    n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 32'hA0000002) begin n_bad++; $display("FAIL basic_c2_write got wr=%b din=%h want wr=1 din=a0000002", bus.fifo_wr_en, bus.fifo_din); end
    @(negedge wclk); drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    n_cmp++; if (pair_cnt !== 16'd1 || grant !== 2'b00) begin n_bad++; $display("FAIL basic_end got cnt=%h grant=%b want cnt=0001 grant=00", pair_cnt, grant); end
  endtask

  task automatic test_back_to_back_pairs;
    int tags[$];
    logic [1:0] eg;
    logic [31:0] d0, d1;
    apply_reset();
    for (int c = 0; c <= 12; c++) begin
      @(negedge wclk);
      d0 = $urandom; d1 = $urandom;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, d0, d1); #1;
      eg = (c % 3 == 0) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
      n_cmp++; if (grant !== eg) begin n_bad++; $display("FAIL b2b_grant c=%0d got %b want %b", c, grant, eg); end
      n_cmp++; if (bus.fifo_wr_en !== (eg != 2'b00)) begin n_bad++; $display("FAIL b2b_wr c=%0d got %b want %b", c, bus.fifo_wr_en, eg != 2'b00); end
      if (eg != 2'b00) begin
        n_cmp++; if (bus.fifo_din !== (eg[1] ? d1 : d0)) begin n_bad++; $display("FAIL b2b_din c=%0d got %h want %h", c, bus.fifo_din, eg[1] ? d1 : d0); end
      end else begin
        n_cmp++; if (pair_cnt !== 16'(c / 3)) begin n_bad++; $display("FAIL b2b_cnt c=%0d got %0d want %0d", c, pair_cnt, c / 3); end
      end
      if (bus.fifo_wr_en === 1'b1) tags.push_back(bus.fifo_din === d1 && bus.fifo_din !== d0 ? 1 : 0);
    end
    n_cmp++; if (tags.size() != 8) begin n_bad++; $display("FAIL b2b_words got %0d want 8", tags.size()); end
    for (int i = 0; i < tags.size(); i++) begin
      n_cmp++; if (tags[i] != (i / 2) % 2) begin n_bad++; $display("FAIL b2b_order idx=%0d got port %0d want port %0d", i, tags[i], (i / 2) % 2); end
    end
    n_cmp++; if (pair_cnt !== 16'd4) begin n_bad++; $display("FAIL b2b_total got %0d want 4", pair_cnt); end
  endtask

  task automatic test_full_in_right;
    apply_reset();
    @(negedge wclk); drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hB0000001); #1;
    @(negedge wclk); #1;
    n_cmp++; if (grant !== 2'b10 || bus.fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL full_left got grant=%b wr=%b want grant=10 wr=1", grant, bus.fifo_wr_en); end
    for (int k = 0; k < 5; k++) begin
      @(negedge wclk); drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'hB0000002); #1;
      n_cmp++; if (bus.s1_ready !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL full_hold k=%0d got ready=%b wr=%b want 0 0", k, bus.s1_ready, bus.fifo_wr_en); end
      n_cmp++; if (pair_err !== 1'b0 || grant !== 2'b10) begin n_bad++; $display("FAIL full_state k=%0d got err=%b grant=%b want 0 10", k, pair_err, grant); end
    end
    @(negedge wclk); drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hB0000002); #1;
    n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 32'hB0000002) begin n_bad++; $display("FAIL full_release got wr=%b din=%h want 1 b0000002", bus.fifo_wr_en, bus.fifo_din); end
    @(negedge wclk); drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    n_cmp++; if (pair_cnt !== 16'd1 || grant !== 2'b00 || pair_err !== 1'b0) begin n_bad++; $display("FAIL full_end got cnt=%0d grant=%b err=%b want 1 00 0", pair_cnt, grant, pair_err); end
  endtask

  task automatic test_enable_drop;
    apply_reset();
    @(negedge wclk); drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC0000001, 32'h0); #1;
    @(negedge wclk); #1;
    n_cmp++; if (grant !== 2'b01 || bus.fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL en_left got grant=%b wr=%b want 01 1", grant, bus.fifo_wr_en); end
    @(negedge wclk); drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC0000002, 32'h0); #1;
    n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 32'hC0000002) begin n_bad++; $display("FAIL en_right got wr=%b din=%h want 1 c0000002", bus.fifo_wr_en, bus.fifo_din); end
    @(negedge wclk); drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC0000003, 32'h0); #1;
    n_cmp++; if (grant !== 2'b00 || pair_cnt !== 16'd1) begin n_bad++; $display("FAIL en_idle got grant=%b cnt=%0d want 00 1", grant, pair_cnt); end
    @(negedge wclk); drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    n_cmp++; if (grant !== 2'b01 || bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL en_left2 got grant=%b wr=%b want 01 0", grant, bus.fifo_wr_en); end
    @(negedge wclk); drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC0000004, 32'h0); #1;
    n_cmp++; if (grant !== 2'b00 || bus.fifo_wr_en !== 1'b0 || pair_cnt !== 16'd1) begin n_bad++; $display("FAIL en_abort got grant=%b wr=%b cnt=%0d want 00 0 1", grant, bus.fifo_wr_en, pair_cnt); end
  endtask

  task automatic test_timeout;
    apply_reset();
    @(negedge wclk); drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hD0000001, 32'h0); #1;
    @(negedge wclk); #1;
    n_cmp++; if (grant !== 2'b01 || bus.fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL tmo_left got grant=%b wr=%b want 01 1", grant, bus.fifo_wr_en); end
`ifdef TXSCHED_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      @(negedge wclk); drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
      n_cmp++; if (pair_err !== 1'b0 || grant !== 2'b01) begin n_bad++; $display("FAIL tmo_stall k=%0d got err=%b grant=%b want 0 01", k, pair_err, grant); end
    end
    @(negedge wclk); #1;
    n_cmp++; if (pair_err !== 1'b1 || grant !== 2'b00 || pair_cnt !== 16'd0 || bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL tmo_abort got err=%b grant=%b cnt=%0d wr=%b want 1 00 0 0", pair_err, grant, pair_cnt, bus.fifo_wr_en); end
    @(negedge wclk); #1;
    n_cmp++; if (pair_err !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse got err=%b want 0", pair_err); end
`else
    for (int k = 1; k <= 100; k++) begin
      @(negedge wclk); drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
      n_cmp++; if (pair_err !== 1'b0 || grant !== 2'b01) begin n_bad++; $display("FAIL tmo_wait k=%0d got err=%b grant=%b want 0 01", k, pair_err, grant); end
    end
    @(negedge wclk); drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hD0000002, 32'h0); #1;
    n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 32'hD0000002) begin n_bad++; $display("FAIL tmo_late got wr=%b din=%h want 1 d0000002", bus.fifo_wr_en, bus.fifo_din); end
    @(negedge wclk); drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    n_cmp++; if (pair_cnt !== 16'd1) begin n_bad++; $display("FAIL tmo_late_cnt got %0d want 1", pair_cnt); end
`endif
  endtask

  task automatic test_mono_wrap;
    logic [1:0] eg;
    apply_reset();
    for (int c = 0; c <= 8; c++) begin
      @(negedge wclk); drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hE0000000 + 32'(c), 32'hF0000000 + 32'(c)); #1;
      eg = (c % 2 == 0) ? 2'b00 : (((c / 2) % 2 == 0) ? 2'b01 : 2'b10);
      n_cmp++; if (grant !== eg) begin n_bad++; $display("FAIL mono_grant c=%0d got %b want %b", c, grant, eg); end
      if (c % 2 == 0) begin
        n_cmp++; if (pair_cnt !== 16'(c / 2)) begin n_bad++; $display("FAIL mono_cnt c=%0d got %0d want %0d", c, pair_cnt, c / 2); end
      end
    end
    @(negedge wclk); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge wclk);
    force dut.pair_cnt_q = 16'hFFFF;
    @(negedge wclk);
    release dut.pair_cnt_q;
    #1;
    n_cmp++; if (pair_cnt !== 16'hFFFF || grant !== 2'b00) begin n_bad++; $display("FAIL wrap_pre got cnt=%h grant=%b want ffff 00", pair_cnt, grant); end
    @(negedge wclk); drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678, 32'h0); #1;
    @(negedge wclk); #1;
    n_cmp++; if (bus.fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL wrap_wr got %b want 1", bus.fifo_wr_en); end
    @(negedge wclk); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    n_cmp++; if (pair_cnt !== 16'h0000) begin n_bad++; $display("FAIL wrap_post got %h want 0000", pair_cnt); end
  endtask

  // Grant-level reference: who owns the port, how many words of the grant are
  // taken, the round-robin memory, and the completed-grant tally.
  task automatic test_random;
    int owner, taken, last, stall;
    logic [15:0] m_cnt;
    logic m_err, st, en, v0, v1, full;
    logic [31:0] d0, d1;
    logic [1:0] eg;
    logic ewr;
    apply_reset();
    owner = -1; taken = 0; last = 1; stall = 0; m_cnt = 16'h0; m_err = 1'b0; st = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge wclk);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) st = ~st;
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 1) != 0);
      full = ($urandom_range(0, 4) == 0);
      d0 = $urandom; d1 = $urandom;
      drive(en, st, v0, v1, full, d0, d1); #1;
      eg  = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
      ewr = ((owner == 0 && v0) || (owner == 1 && v1)) && !full;
      n_cmp++; if (grant !== eg) begin n_bad++; $display("FAIL rnd_grant n=%0d got %b want %b", n, grant, eg); end
      n_cmp++; if ({bus.s1_ready, bus.s0_ready} !== (full ? 2'b00 : eg)) begin n_bad++; $display("FAIL rnd_ready n=%0d got %b want %b", n, {bus.s1_ready, bus.s0_ready}, full ? 2'b00 : eg); end
      n_cmp++; if (bus.fifo_wr_en !== ewr) begin n_bad++; $display("FAIL rnd_wr n=%0d got %b want %b", n, bus.fifo_wr_en, ewr); end
      n_cmp++; if (bus.fifo_din !== ((owner == 1) ? d1 : d0)) begin n_bad++; $display("FAIL rnd_din n=%0d got %h want %h", n, bus.fifo_din, (owner == 1) ? d1 : d0); end
      n_cmp++; if (pair_cnt !== m_cnt) begin n_bad++; $display("FAIL rnd_cnt n=%0d got %h want %h", n, pair_cnt, m_cnt); end
      n_cmp++; if (pair_err !== m_err) begin n_bad++; $display("FAIL rnd_err n=%0d got %b want %b", n, pair_err, m_err); end
      m_err = 1'b0;
      if (owner < 0) begin
        if (en && (v0 || v1)) begin
          owner = (v0 && v1) ? ((last == 1) ? 0 : 1) : (v0 ? 0 : 1);
          taken = 0;
        end
      end else if (ewr) begin
        if (taken == 0 && st) begin
          taken = 1; stall = 0;
        end else begin
          m_cnt = m_cnt + 16'd1; last = owner; owner = -1;
        end
      end else if (taken == 0) begin
        if (!en) owner = -1;
      end else begin
`ifdef TXSCHED_TIMEOUT_EN
        if (!full) begin
          stall++;
          if (stall == TMO) begin m_err = 1'b1; last = owner; owner = -1; end
        end
`endif
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_pair_basic();
    test_back_to_back_pairs();
    test_full_in_right();
    test_enable_drop();
    test_timeout();
    test_mono_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
